// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_if
// Purpose  : EX-stage <-> multiply/divide unit handshake and operand bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_muldiv_if #(
    parameter int DATA_W = 32
);
    logic                  start_i;
    logic                  annul_i;
    logic [2:0]            op_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [DATA_W-1:0]     hi_i;
    logic [DATA_W-1:0]     lo_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;
    logic                  stallreq_o;

    modport master (
        output start_i, annul_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i,
        input  result_o, ready_o, busy_o, stallreq_o
    );

    modport slave (
        input  start_i, annul_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i,
        output result_o, ready_o, busy_o, stallreq_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU unit producing {HI,LO}; define
//            MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ex_muldiv_if.slave bus
);
    localparam int c_CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
`ifdef MULDIV_MADD_EN
    localparam logic c_MADD_EN = 1'b1;
`else
    localparam logic c_MADD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL      = 3'd1,
        S_DIV_ZERO = 3'd2,
        S_DIV      = 3'd3,
        S_DONE     = 3'd4,
        S_ACC      = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_op;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_quo;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0]   r_result;
    logic [2*DATA_W-1:0]   w_acc;

    function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? -v : v;
    endfunction

    // Signed ops have op[0]=0; magnitudes feed both the multiplier and divider.
    logic                  w_sgn;
    logic [DATA_W-1:0]     w_mag_a;
    logic [DATA_W-1:0]     w_mag_b;
    logic [2*DATA_W-1:0]   w_umul;
    logic [2*DATA_W-1:0]   w_prod;
    logic                  w_neg_q;
    logic                  w_neg_r;
    logic [DATA_W:0]       w_shift;
    logic                  w_fits;
    logic [DATA_W-1:0]     w_rem_sub;
    logic [DATA_W-1:0]     w_quo_s;
    logic [DATA_W-1:0]     w_rem_s;
    logic                  w_illegal;
    logic                  w_mul_last;
    logic                  w_div_last;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_abort;

    assign w_sgn      = ~r_op[0];
    assign w_mag_a    = f_abs(r_a, w_sgn);
    assign w_mag_b    = f_abs(r_b, w_sgn);
    assign w_umul     = {{DATA_W{1'b0}}, w_mag_a} * {{DATA_W{1'b0}}, w_mag_b};
    assign w_neg_q    = w_sgn & (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
    assign w_neg_r    = w_sgn & r_a[DATA_W-1];
    assign w_prod     = w_neg_q ? -w_umul : w_umul;

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_shift    = {r_rem, r_quo[DATA_W-1]};
    assign w_fits     = w_shift[DATA_W] | (w_shift[DATA_W-1:0] >= w_mag_b);
    assign w_rem_sub  = w_shift[DATA_W-1:0] - w_mag_b;
    assign w_quo_s    = w_neg_q ? -r_quo : r_quo;
    assign w_rem_s    = w_neg_r ? -r_rem : r_rem;

    assign w_illegal  = r_op[2] & ~c_MADD_EN;
    assign w_mul_last = (r_cnt == c_CNT_W'(MUL_LAT - 1));
    assign w_div_last = (r_cnt == c_CNT_W'(DATA_W));

    assign w_busy     = (r_state == S_MUL) || (r_state == S_DIV_ZERO) ||
                        (r_state == S_DIV) || (r_state == S_ACC);
    assign w_accept   = (r_state == S_IDLE) && bus.start_i && !bus.annul_i;
    assign w_abort    = w_busy && (bus.annul_i || !bus.start_i);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.op_i[2])
                        w_state_next = c_MADD_EN ? S_MUL : S_DIV_ZERO;
                    else if (bus.op_i[1])
                        w_state_next = (bus.opdata2_i == '0) ? S_DIV_ZERO : S_DIV;
                    else
                        w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (w_abort)         w_state_next = S_IDLE;
                else if (w_mul_last) w_state_next = r_op[2] ? S_ACC : S_DONE;
            end
            S_ACC, S_DIV_ZERO: begin
                w_state_next = w_abort ? S_IDLE : S_DONE;
            end
            S_DIV: begin
                if (w_abort)         w_state_next = S_IDLE;
                else if (w_div_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (!bus.start_i || bus.annul_i) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef MULDIV_MADD_EN
    logic [2*DATA_W-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst)           r_acc <= '0;
        else if (w_accept) r_acc <= {bus.hi_i, bus.lo_i};
    end

    assign w_acc = r_acc;
`else
    assign w_acc = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= bus.op_i;
            r_a   <= bus.opdata1_i;
            r_b   <= bus.opdata2_i;
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= f_abs(bus.opdata1_i, ~bus.op_i[0]);
        end else if (w_abort) begin
            r_result <= '0;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_mul_last) r_result <= w_prod;
                end
                S_ACC: begin
                    r_result <= r_op[1] ? (w_acc - w_prod) : (w_acc + w_prod);
                end
                // Illegal ops share this one-cycle slot but complete with zero.
                S_DIV_ZERO: begin
                    r_result <= w_illegal ? '0 : {r_a, {DATA_W{1'b1}}};
                end
                S_DIV: begin
                    if (w_div_last) begin
                        r_result <= {w_rem_s, w_quo_s};
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        r_rem <= w_fits ? w_rem_sub : w_shift[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], w_fits};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_o   = r_result;
    assign bus.ready_o    = (r_state == S_DONE);
    assign bus.busy_o     = w_busy;
    assign bus.stallreq_o = bus.start_i & ~bus.ready_o;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Purpose  : Self-checking bench for ex_muldiv against an arithmetic model;
//            honours MULDIV_MADD_EN for the accumulate ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.DATA_W(DATA_W)) bus ();

    ex_muldiv #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = op[0] ? ({32'b0, a} * {32'b0, b}) : 64'(sa * sb);
        case (op)
            3'd0, 3'd1: return p;
            3'd2: return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            3'd3: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
`ifdef MULDIV_MADD_EN
                return op[1] ? ({hi, lo} - p) : ({hi, lo} + p);
`else
                return (hi == hi) ? 64'd0 : {lo, 32'd0};
`endif
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] b);
        if (op[2]) begin
`ifdef MULDIV_MADD_EN
            return MUL_LAT + 1;
`else
            return 1;
`endif
        end
        if (op[1]) return (b == 0) ? 1 : DATA_W + 1;
        return MUL_LAT;
    endfunction

    // Issue one op from a negedge, scramble the bus after acceptance, hold start.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input int hold);
        logic [63:0] exp;
        int          lat;
        logic        busy_ok;
        logic        stall_ok;
        logic        stable_ok;
        exp = model(op, a, b, hi, lo);
        bus.op_i      = op;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.hi_i      = hi;
        bus.lo_i      = lo;
        bus.annul_i   = 1'b0;
        bus.start_i   = 1'b1;
        @(posedge clk);
        #1;
        bus.op_i      = 3'($urandom);
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
        bus.hi_i      = $urandom;
        bus.lo_i      = $urandom;
        lat      = 0;
        busy_ok  = 1'b1;
        stall_ok = 1'b1;
        @(negedge clk);
        while (!bus.ready_o && lat < 100) begin
            if (!bus.busy_o)     busy_ok  = 1'b0;
            if (!bus.stallreq_o) stall_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(lat), 64'(latency(op, b)));
        check({tag, " busy while running"}, 64'(busy_ok), 64'd1);
        check({tag, " stall while running"}, 64'(stall_ok), 64'd1);
        check({tag, " result"}, bus.result_o, exp);
        check({tag, " stall at ready"}, 64'(bus.stallreq_o), 64'd0);
        if (hold > 0) begin
            stable_ok = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!bus.ready_o || bus.busy_o || bus.result_o !== exp) stable_ok = 1'b0;
            end
            check({tag, " held in DONE"}, 64'(stable_ok), 64'd1);
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        check({tag, " ready drops"}, 64'(bus.ready_o), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic seen_ready;
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.annul_i   = 1'b0;
        bus.op_i      = 3'd0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.hi_i      = '0;
        bus.lo_i      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset result", bus.result_o, 64'd0);
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset busy", 64'(bus.busy_o), 64'd0);
        check("reset stall", 64'(bus.stallreq_o), 64'd0);

        run_op("MULT -2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 0);
        run_op("MULTU max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1);
        run_op("DIV -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 0);
        run_op("DIVU 100/0", 3'd3, 32'd100, 32'd0, 32'd0, 32'd0, 3);
        run_op("DIV overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 0);
        run_op("DIV 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 0);
        run_op("op 100", 3'd4, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd5, 1);
        run_op("op 111", 3'd7, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd5, 0);

        // Annul mid-divide: no ready pulse, result cleared.
        bus.op_i      = 3'd2;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        seen_ready    = 1'b0;
        @(posedge clk);
        repeat (9) begin
            @(negedge clk);
            if (bus.ready_o) seen_ready = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        if (bus.ready_o) seen_ready = 1'b1;
        check("annul busy", 64'(bus.busy_o), 64'd0);
        check("annul result", bus.result_o, 64'd0);
        repeat (3) begin
            @(negedge clk);
            if (bus.ready_o) seen_ready = 1'b1;
        end
        check("annul no ready", 64'(seen_ready), 64'd0);
        run_op("MULT 3x4", 3'd0, 32'd3, 32'd4, 32'd0, 32'd0, 0);

        // Synchronous reset mid-divide.
        bus.op_i      = 3'd3;
        bus.opdata1_i = 32'd12345;
        bus.opdata2_i = 32'd17;
        bus.start_i   = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midop reset busy", 64'(bus.busy_o), 64'd0);
        check("midop reset result", bus.result_o, 64'd0);

        // Annul wins over a simultaneous request in IDLE.
        bus.op_i      = 3'd1;
        bus.opdata1_i = 32'd7;
        bus.opdata2_i = 32'd9;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("annul priority busy", 64'(bus.busy_o), 64'd0);
        bus.annul_i = 1'b0;
        run_op("MULTU 7x9", 3'd1, 32'd7, 32'd9, 32'd0, 32'd0, 0);

        // Dropping start while busy aborts the multiply.
        bus.op_i      = 3'd0;
        bus.opdata1_i = 32'd5;
        bus.opdata2_i = 32'd6;
        bus.start_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("start drop busy", 64'(bus.busy_o), 64'd0);
        check("start drop result", bus.result_o, 64'd0);
        check("start drop ready", 64'(bus.ready_o), 64'd0);

        for (int i = 0; i < 80; i++) begin
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick_operand(),
                   pick_operand(), $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit alongside the EX stage ALU.
- Executes MULT/MULTU/DIV/DIVU, plus optional multiply-accumulate, and produces a {HI,LO} result.
- Raises a stall request so the pipeline holds while the operation is in progress.
- The EX stage muxes result_o onto hi_o/lo_o with whilo_o asserted when ready_o is seen.

Parameters:
- DATA_W, 32: operand width; HI and LO are each DATA_W wide.
- MUL_LAT, 2: multiply latency in cycles from acceptance to ready_o (>=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high (RstEnable = 1'b1).
- start_i  in  1  operation request; held high by EX until ready_o is seen.
- annul_i  in  1  flush; abort the current operation.
- op_i  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- opdata1_i  in  DATA_W  rs operand (multiplicand / dividend).
- opdata2_i  in  DATA_W  rt operand (multiplier / divisor).
- hi_i  in  DATA_W  forwarded HI value (accumulate ops only).
- lo_i  in  DATA_W  forwarded LO value (accumulate ops only).
- result_o  out  2*DATA_W  {HI,LO} result.
- ready_o  out  1  result valid.
- busy_o  out  1  operation in progress.
- stallreq_o  out  1  pipeline stall request.

Behaviour:
- Reset: state=IDLE; result_o=0, ready_o=0, busy_o=0; counter=0.
- States:
  - IDLE: waiting for start_i.
  - MUL: multiply in progress.
  - DIV_ZERO: divide by zero detected.
  - DIV: division iterating.
  - DONE: result held.
- Acceptance:
  - IDLE with start_i=1 and annul_i=0: op and operands are latched; the unit leaves IDLE the next cycle.
  - Operands are not re-sampled after acceptance.
- MUL path:
  - Signed ops use two's-complement absolute values; the product is negated if the operand signs differ.
  - Full 2*DATA_W product.
  - ready_o rises exactly MUL_LAT cycles after the accept edge.
- DIV path:
  - Divisor==0: go to DIV_ZERO for 1 cycle, then DONE with result_o = {opdata1, all-ones}.
  - Otherwise iterative restoring radix-2 division, 1 quotient bit per cycle for DATA_W cycles, then DONE.
  - ready_o rises DATA_W+1 cycles after the accept edge.
- DIV signs:
  - Signed divide works on absolute values.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - result_o = {remainder, quotient}.
- DIV overflow case: -2^(W-1)/-1 yields LO=0x80000000, HI=0 (W=32), with no exception.
- DONE:
  - ready_o=1 and result_o is stable.
  - The unit stays in DONE while start_i=1 (no re-issue).
  - Goes to IDLE the cycle after start_i=0.
- busy_o = 1 in MUL, DIV_ZERO and DIV.
- stallreq_o = start_i & ~ready_o (combinational), so the stall drops in the same cycle ready_o rises.
- Abort:
  - annul_i=1, or start_i=0 while busy: return to IDLE on the next edge.
  - No ready_o pulse; result_o is cleared to 0.
  - annul_i has priority over acceptance in IDLE.
- rst asserted mid-operation: same as reset, next edge.
- Ops 1xx when the feature is disabled: treated as illegal; one-cycle path to DONE with result_o=0.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- When defined:
  - Ops 100-111 perform the product as in the MUL path, then take one extra ACC cycle.
  - MADD/MADDU: {hi_i,lo_i} + product.
  - MSUB/MSUBU: {hi_i,lo_i} - product.
  - The addition is modulo 2^(2W).
  - hi_i/lo_i are latched at acceptance.
  - ready_o rises MUL_LAT+1 cycles after the accept edge.
- When undefined: hi_i/lo_i are unused and ops 1xx follow the illegal rule above.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003 -> after 2 cycles result_o=0xFFFFFFFF_FFFFFFFA, ready_o=1, stallreq_o=0 that cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0xFFFFFFFE_00000001.
- DIV -7 / 2 -> after 33 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); busy_o=1 throughout.
- DIVU 100 / 0 -> DIV_ZERO then DONE: HI=100, LO=0xFFFFFFFF; start_i held 3 extra cycles -> unit stays in DONE, no second op.
- DIV 1000/7 with annul_i pulsed at cycle 10 -> IDLE next cycle, ready_o never asserts, result_o=0; a new MULT 3x4 issued next gives result_o=12.
- MULDIV_MADD_EN: MADD hi/lo=0x0_00000005, 0xFFFFFFFF x 2 -> result_o=0x00000000_00000003 (signed -2+5); MSUBU on the same inputs -> 0xFFFFFFFE_00000007.
